// File: rtl/tlb_pkg.sv
// tlb_pkg: shared TLBELO field layout, write mask helper and TLBRD FSM encoding
package tlb_pkg;

   localparam int V_BIT   = 0;
   localparam int D_BIT   = 1;
   localparam int PLV_LSB = 2;
   localparam int MAT_LSB = 4;
   localparam int G_BIT   = 6;
   localparam int PPN_LSB = 8;

   // Full-width view of an EntryLo at PALEN=32; narrower PALEN zeroes upper PPN bits
   typedef struct packed {
      logic [3:0]  rsv_hi;
      logic [19:0] ppn;
      logic        rsv7;
      logic        g;
      logic [1:0]  mat;
      logic [1:0]  plv;
      logic        d;
      logic        v;
   } tlbelo_t;

   typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} fsm_t;

   // Writable bits: V..G in [6:0] plus PPN in [PALEN-5:8]; bit 7 and bits above PPN stay 0
   function automatic logic [31:0] wr_mask(input int palen);
      return ((32'd1 << (palen - 4)) - 32'd1) & ~32'h0000_0080;
   endfunction

endpackage

// File: rtl/tlbelo_reg.sv
// tlbelo_reg: one EntryLo register with masked CSR write and a higher-priority load port
module tlbelo_reg
   import tlb_pkg::*;
#(
   parameter int PALEN = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we,
   input  logic [31:0] wdata,
   input  logic [31:0] wmask,
   input  logic        ld,
   input  logic [31:0] ld_data,
   output logic [31:0] q
);

   localparam logic [31:0] WR_MASK = wr_mask(PALEN);

   // Load beats CSR write; reserved bits are stripped on every update
   always_ff @(posedge clk) begin
      if (!rst_n) q <= '0;
      else if (ld) q <= ld_data & WR_MASK;
      else if (we) q <= ((q & ~wmask) | (wdata & wmask)) & WR_MASK;
   end

endmodule

// File: rtl/tlbelo_csr_bank.sv
// tlbelo_csr_bank: NUM_LO EntryLo CSRs with CSR access and TLBRD load handshake
// TLBELO_CSRXCHG_EN: when defined csr_wmask is honoured (csrxchg); otherwise writes use an all-ones mask
module tlbelo_csr_bank
   import tlb_pkg::*;
#(
   parameter  int PALEN     = 32,
   parameter  int NUM_LO    = 2,
   parameter  int TLB_IDX_W = 4,
   localparam int SEL_W     = (NUM_LO > 1) ? $clog2(NUM_LO) : 1,
   localparam int PPN_W     = PALEN - 12
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    csr_we,
   input  logic [SEL_W-1:0]        csr_sel,
   input  logic [31:0]             csr_wdata,
   input  logic [31:0]             csr_wmask,
   output logic [31:0]             csr_rdata,
   input  logic                    tlbrd_start,
   input  logic [TLB_IDX_W-1:0]    tlbrd_idx,
   output logic                    tlb_rd_req,
   output logic [TLB_IDX_W-1:0]    tlb_rd_idx,
   input  logic                    tlb_rd_ack,
   input  logic                    tlb_rd_e,
   input  logic [NUM_LO*PPN_W-1:0] tlb_rd_ppn,
   input  logic [NUM_LO*6-1:0]     tlb_rd_flags,
   input  logic                    tlb_rd_g,
   output logic                    tlbrd_busy,
   output logic                    tlbrd_done,
   output logic [NUM_LO*32-1:0]    tlbelo_flat
);

   fsm_t        state;
   logic        ld;
   logic [31:0] mask;
   logic [31:0] q [NUM_LO];

`ifdef TLBELO_CSRXCHG_EN
   assign mask = csr_wmask;
`else
   logic unused_wmask;
   assign unused_wmask = ^csr_wmask;
   assign mask = '1;
`endif

   assign ld         = (state == REQ) && tlb_rd_ack;
   assign tlb_rd_req = (state == REQ);
   assign tlbrd_busy = (state != IDLE);
   assign csr_rdata  = (32'(csr_sel) < NUM_LO) ? q[csr_sel] : '0;

   // TLBRD handshake: latch index on start, hold req until ack, pulse done on the load edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         tlb_rd_idx <= '0;
         tlbrd_done <= 1'b0;
      end else begin
         tlbrd_done <= ld;
         if (state == IDLE && tlbrd_start) begin
            state      <= REQ;
            tlb_rd_idx <= tlbrd_idx;
         end else if (ld) state <= IDLE;
      end
   end

   for (genvar k = 0; k < NUM_LO; k++) begin : g_lo
      logic [31:0] ld_data;
      assign ld_data = tlb_rd_e ? 32'({tlb_rd_ppn[k*PPN_W +: PPN_W], 1'b0, tlb_rd_g, tlb_rd_flags[k*6 +: 6]}) : 32'd0;
      tlbelo_reg #(.PALEN(PALEN)) u_reg (
         .clk    (clk),
         .rst_n  (rst_n),
         .we     (csr_we && csr_sel == SEL_W'(k)),
         .wdata  (csr_wdata),
         .wmask  (mask),
         .ld     (ld),
         .ld_data(ld_data),
         .q      (q[k])
      );
      assign tlbelo_flat[32*k +: 32] = q[k];
   end

endmodule

// File: tb/tb_tlbelo_csr_bank.sv
// tb_tlbelo_csr_bank: directed checks of the default bank and a PALEN=20, NUM_LO=4 bank
module tb_tlbelo_csr_bank;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  always #5 clk = ~clk;
  logic        a_we, a_sel, a_start, a_req, a_ack, a_e, a_g, a_busy, a_done;
  logic [31:0] a_wdata, a_wmask, a_rdata;
  logic [3:0]  a_idx, a_rd_idx;
  logic [39:0] a_ppn;
  logic [11:0] a_flags;
  logic [63:0] a_flat;
  logic        b_we, b_start, b_req, b_ack, b_e, b_g, b_busy, b_done;
  logic [1:0]  b_sel;
  logic [31:0] b_wdata, b_wmask, b_rdata;
  logic [3:0]  b_idx, b_rd_idx;
  logic [31:0] b_ppn;
  logic [23:0] b_flags;
  logic [127:0] b_flat;
  tlbelo_csr_bank dut_a (
    .clk(clk), .rst_n(rst_n), .csr_we(a_we), .csr_sel(a_sel), .csr_wdata(a_wdata),
    .csr_wmask(a_wmask), .csr_rdata(a_rdata), .tlbrd_start(a_start), .tlbrd_idx(a_idx),
    .tlb_rd_req(a_req), .tlb_rd_idx(a_rd_idx), .tlb_rd_ack(a_ack), .tlb_rd_e(a_e),
    .tlb_rd_ppn(a_ppn), .tlb_rd_flags(a_flags), .tlb_rd_g(a_g), .tlbrd_busy(a_busy),
    .tlbrd_done(a_done), .tlbelo_flat(a_flat)
  );
  tlbelo_csr_bank #(.PALEN(20), .NUM_LO(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .csr_we(b_we), .csr_sel(b_sel), .csr_wdata(b_wdata),
    .csr_wmask(b_wmask), .csr_rdata(b_rdata), .tlbrd_start(b_start), .tlbrd_idx(b_idx),
    .tlb_rd_req(b_req), .tlb_rd_idx(b_rd_idx), .tlb_rd_ack(b_ack), .tlb_rd_e(b_e),
    .tlb_rd_ppn(b_ppn), .tlb_rd_flags(b_flags), .tlb_rd_g(b_g), .tlbrd_busy(b_busy),
    .tlbrd_done(b_done), .tlbelo_flat(b_flat)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic a_write(input logic sel, input logic [31:0] d, input logic [31:0] m);
    a_we = 1'b1; a_sel = sel; a_wdata = d; a_wmask = m;
    tick();
    a_we = 1'b0;
  endtask
  logic [31:0] xchg_exp;
  initial begin
    #100000;
    fails++;
    $error("FAIL timeout: wait expired");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    rst_n = 1'b0;
    a_we = 0; a_sel = 0; a_wdata = 0; a_wmask = '1; a_start = 0; a_idx = 0;
    a_ack = 0; a_e = 0; a_g = 0; a_ppn = 0; a_flags = 0;
    b_we = 0; b_sel = 0; b_wdata = 0; b_wmask = '1; b_start = 0; b_idx = 0;
    b_ack = 0; b_e = 0; b_g = 0; b_ppn = 0; b_flags = 0;
    tick();
    chk("rst_flat", a_flat, 64'h0);
    chk("rst_req", a_req, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_done", a_done, 1'b0);
    rst_n = 1'b1;
    a_write(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    a_sel = 1'b1;
    chk("wr_mask_sel1", a_rdata, 32'h0FFF_FF7F);
    chk("wr_sel0_untouched", a_flat[31:0], 32'h0);
    a_idx = 4'd5; a_start = 1'b1;
    tick();
    a_start = 1'b0; a_idx = 4'd9;
    chk("hit_req", a_req, 1'b1);
    chk("hit_busy", a_busy, 1'b1);
    chk("hit_idx0", a_rd_idx, 4'd5);
    tick();
    chk("hit_idx1", a_rd_idx, 4'd5);
    tick();
    chk("hit_idx2", a_rd_idx, 4'd5);
    chk("hit_no_early_done", a_done, 1'b0);
    a_ack = 1'b1; a_e = 1'b1; a_g = 1'b1;
    a_ppn = {20'h0ABCD, 20'h12345}; a_flags = {6'h2F, 6'h13};
    tick();
    a_ack = 1'b0;
    chk("hit_done", a_done, 1'b1);
    chk("hit_req_drop", a_req, 1'b0);
    chk("hit_reg0", a_flat[31:0], 32'h0123_4553);
    chk("hit_reg1", a_flat[63:32], 32'h00AB_CD6F);
    tick();
    chk("hit_done_pulse", a_done, 1'b0);
    a_ack = 1'b1; a_flags = 12'hFFF;
    tick();
    a_ack = 1'b0;
    chk("idle_ack_done", a_done, 1'b0);
    chk("idle_ack_reg0", a_flat[31:0], 32'h0123_4553);
    a_write(1'b0, 32'hFFFF_FF7F, 32'hFFFF_FFFF);
    a_write(1'b1, 32'hFFFF_FF7F, 32'hFFFF_FFFF);
    chk("miss_pre0", a_flat[31:0], 32'h0FFF_FF7F);
    chk("miss_pre1", a_flat[63:32], 32'h0FFF_FF7F);
    a_start = 1'b1;
    tick();
    a_start = 1'b0; a_e = 1'b0; a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    chk("miss_flat", a_flat, 64'h0);
    chk("miss_done", a_done, 1'b1);
    tick();
    chk("miss_done_once", a_done, 1'b0);
    a_idx = 4'd3; a_start = 1'b1;
    tick();
    a_idx = 4'd7;
    tick();
    a_start = 1'b0;
    chk("busy_start_idx", a_rd_idx, 4'd3);
    a_e = 1'b1; a_flags = {6'h2F, 6'h13}; a_ack = 1'b1;
    a_we = 1'b1; a_sel = 1'b0; a_wdata = 32'h1; a_wmask = '1;
    tick();
    a_ack = 1'b0; a_we = 1'b0;
    chk("coll_reg0", a_flat[31:0], 32'h0123_4553);
    chk("coll_done", a_done, 1'b1);
    tick();
    chk("coll_no_req2", a_req, 1'b0);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_write(1'b1, 32'h0000_0100, 32'hFFFF_FFFF);
    chk("busy_wr_reg1", a_flat[63:32], 32'h0000_0100);
    chk("busy_wr_still_busy", a_busy, 1'b1);
    a_e = 1'b0; a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    a_write(1'b0, 32'h0000_0155, 32'hFFFF_FFFF);
    a_write(1'b0, 32'h0000_0002, 32'h0000_0003);
`ifdef TLBELO_CSRXCHG_EN
    xchg_exp = 32'h0000_0156;
`else
    xchg_exp = 32'h0000_0002;
`endif
    a_sel = 1'b0;
    chk("xchg_reg0", a_rdata, xchg_exp);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_req", a_req, 1'b0);
    chk("midrst_busy", a_busy, 1'b0);
    chk("midrst_flat", a_flat, 64'h0);
    b_we = 1'b1; b_sel = 2'd3; b_wdata = 32'hFFFF_FFFF;
    tick();
    b_we = 1'b0;
    chk("b_wr_sel3", b_rdata, 32'h0000_FF7F);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    b_e = 1'b1; b_g = 1'b1; b_ack = 1'b1;
    b_ppn = 32'h4433_2211; b_flags = {6'h3F, 6'h00, 6'h2A, 6'h15};
    tick();
    b_ack = 1'b0;
    chk("b_reg0", b_flat[31:0], 32'h0000_1155);
    chk("b_reg1", b_flat[63:32], 32'h0000_226A);
    chk("b_reg2", b_flat[95:64], 32'h0000_3340);
    chk("b_reg3", b_flat[127:96], 32'h0000_447F);
    chk("b_done", b_done, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
